alu_uart_sequencer: RTL and testbench

Controller that sits between the UART receiver, the ALU and the UART transmitter. It collects the operand/opcode byte stream (A, then B, then OP) from the receiver and presents all three to the ALU at once. It then captures the result, launches one transmit frame and waits for it to finish. It adds an inter-byte timeout, measured in baud ticks, and an overrun flag for bytes that arrive while a result is in flight.

---
 rtl/alu_uart_pkg.sv | 33 +++
 rtl/tick_timeout.sv | 31 +++
 rtl/alu_uart_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_uart_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART/ALU command sequencer:
// state encoding, default timing and ALU opcodes.
package alu_uart_pkg;

    localparam int N_BITS_DEF        = 8;
    localparam int TIMEOUT_TICKS_DEF = 640;

    localparam logic [2:0] S_WAIT_A  = 3'd0;
    localparam logic [2:0] S_WAIT_B  = 3'd1;
    localparam logic [2:0] S_WAIT_OP = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;
    localparam logic [2:0] S_WAIT_TX = 3'd5;

    typedef enum logic [2:0] {
        ST_WAIT_A  = S_WAIT_A,
        ST_WAIT_B  = S_WAIT_B,
        ST_WAIT_OP = S_WAIT_OP,
        ST_LATCH   = S_LATCH,
        ST_SEND    = S_SEND,
        ST_WAIT_TX = S_WAIT_TX
    } state_t;

    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27;
    localparam logic [7:0] OP_SRA = 8'h03;
    localparam logic [7:0] OP_SRL = 8'h02;

endpackage

// File: rtl/tick_timeout.sv
// Clearable, enable-gated baud-tick counter; o_expire is asserted on
// the tick that completes TIMEOUT_TICKS counts.
module tick_timeout #(
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_tick,
    output logic o_expire
);

    localparam int CW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_TICKS - 1);

    logic [CW-1:0] r_cnt;

    assign o_expire = i_en & i_tick & (r_cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr | o_expire) begin
            r_cnt <= '0;
        end else if (i_en & i_tick) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects A, B, OP from the UART receiver, commits them to the ALU
// together, then transmits the result and waits for the frame to finish.
module alu_uart_sequencer
    import alu_uart_pkg::*;
#(
    parameter int N_BITS        = N_BITS_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_s_tick,
    input  logic [N_BITS-1:0] i_rx_data,
    input  logic              i_rx_done,
    input  logic              i_tx_done,
    input  logic [N_BITS-1:0] i_alu_res,
    output logic [N_BITS-1:0] o_A,
    output logic [N_BITS-1:0] o_B,
    output logic [N_BITS-1:0] o_OP,
    output logic [N_BITS-1:0] o_tx_data,
    output logic              o_tx_start,
    output logic              o_busy,
    output logic              o_timeout,
    output logic              o_overrun
);

    state_t            r_state;
    logic [N_BITS-1:0] r_sh_a;
    logic [N_BITS-1:0] r_sh_b;
    logic              w_collecting;
    logic              w_in_flight;
    logic              w_expire;

    assign w_collecting = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
    assign w_in_flight  = (r_state == ST_LATCH) || (r_state == ST_SEND) ||
                          (r_state == ST_WAIT_TX);

    // Counter is held at zero outside WAIT_B/WAIT_OP and on every byte.
    tick_timeout #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_tick_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_collecting),
        .i_clr    (i_rx_done | ~w_collecting),
        .i_tick   (i_s_tick),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_WAIT_A;
            r_sh_a     <= '0;
            r_sh_b     <= '0;
            o_A        <= '0;
            o_B        <= '0;
            o_OP       <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_timeout  <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_timeout  <= 1'b0;
            o_overrun  <= i_rx_done & w_in_flight;
            unique case (r_state)
                ST_WAIT_A: begin
                    if (i_rx_done) begin
                        r_sh_a  <= i_rx_data;
                        r_state <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (i_rx_done) begin
                        r_sh_b  <= i_rx_data;
                        r_state <= ST_WAIT_OP;
                    end else if (w_expire) begin
                        o_timeout <= 1'b1;
                        r_sh_a    <= '0;
                        r_sh_b    <= '0;
                        r_state   <= ST_WAIT_A;
                    end
                end
                ST_WAIT_OP: begin
                    // A byte arriving on the expiry tick still wins.
                    if (i_rx_done) begin
                        o_A     <= r_sh_a;
                        o_B     <= r_sh_b;
                        o_OP    <= i_rx_data;
                        o_busy  <= 1'b1;
                        r_state <= ST_LATCH;
                    end else if (w_expire) begin
                        o_timeout <= 1'b1;
                        r_sh_a    <= '0;
                        r_sh_b    <= '0;
                        r_state   <= ST_WAIT_A;
                    end
                end
                ST_LATCH: begin
                    o_tx_data  <= i_alu_res;
                    o_tx_start <= 1'b1;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    r_state <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        o_busy  <= 1'b0;
                        r_state <= ST_WAIT_A;
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= ST_WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Randomized self-checking bench for alu_uart_sequencer; the bench
// also plays the ALU and the UART transmitter.
module tb_alu_uart_sequencer;
    import alu_uart_pkg::*;

    localparam int NB = 8;
    localparam int TT = 640;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_tick;
    logic [NB-1:0] rx_data;
    logic          rx_done;
    logic          tx_done;
    logic [NB-1:0] alu_res;
    logic [NB-1:0] o_a, o_b, o_op, tx_data;
    logic          tx_start, busy, to_p, ovr_p;

    int n_checks = 0;
    int n_err    = 0;
    int exp_start = 0, exp_to = 0, exp_ovr = 0;
    int mon_start = 0, mon_to = 0, mon_ovr = 0;

    logic [7:0] ops [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR,
                            OP_XOR, OP_NOR, OP_SRA, OP_SRL};
    logic [7:0] a, b, op;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(logic [7:0] x, logic [7:0] y,
                                         logic [7:0] f);
        case (f)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_NOR:  return ~(x | y);
            OP_SRA:  return 8'($signed(x) >>> y);
            OP_SRL:  return x >> y;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_res = alu_f(o_a, o_b, o_op);

    alu_uart_sequencer #(.N_BITS(NB), .TIMEOUT_TICKS(TT)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .i_s_tick   (s_tick),
        .i_rx_data  (rx_data),
        .i_rx_done  (rx_done),
        .i_tx_done  (tx_done),
        .i_alu_res  (alu_res),
        .o_A        (o_a),
        .o_B        (o_b),
        .o_OP       (o_op),
        .o_tx_data  (tx_data),
        .o_tx_start (tx_start),
        .o_busy     (busy),
        .o_timeout  (to_p),
        .o_overrun  (ovr_p)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_start) mon_start++;
            if (to_p)     mon_to++;
            if (ovr_p)    mon_ovr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v, input logic t);
        rx_data = v;
        rx_done = 1'b1;
        s_tick  = t;
        cyc();
        rx_done = 1'b0;
        s_tick  = 1'b0;
    endtask

    // Idle cycles with sparse ticks and stray tx_done strobes.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            s_tick  = ($urandom_range(0, 99) < 30);
            tx_done = ($urandom_range(0, 9) == 0);
            cyc();
        end
        s_tick  = 1'b0;
        tx_done = 1'b0;
    endtask

    task automatic check_commit(input logic [7:0] x, input logic [7:0] y,
                                input logic [7:0] f);
        check("A", o_a, x);
        check("B", o_b, y);
        check("OP", o_op, f);
        check("busy_latch", busy, 1);
        check("no_timeout", to_p, 0);
        check("start_early", tx_start, 0);
        cyc();
        check("tx_start", tx_start, 1);
        check("tx_data", tx_data, alu_f(x, y, f));
        exp_start++;
        cyc();
        check("start_single", tx_start, 0);
        check("busy_wait", busy, 1);
    endtask

    task automatic issue(input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] f, input int ga, input int gb);
        send(x, 1'b0);
        idle(ga);
        send(y, 1'b0);
        idle(gb);
        send(f, 1'b0);
        check_commit(x, y, f);
    endtask

    task automatic release_tx(input int w, input bit rnd_ovr);
        logic r;
        for (int i = 0; i < w; i++) begin
            r = rnd_ovr && ($urandom_range(0, 2) == 0);
            rx_data = 8'($urandom_range(0, 255));
            rx_done = r;
            cyc();
            rx_done = 1'b0;
            check("ovr_wait", ovr_p, r);
            check("busy_tx", busy, 1);
            if (r) exp_ovr++;
        end
        r = rnd_ovr && ($urandom_range(0, 1) == 0);
        rx_done = r;
        tx_done = 1'b1;
        cyc();
        rx_done = 1'b0;
        tx_done = 1'b0;
        check("ovr_done", ovr_p, r);
        check("busy_idle", busy, 0);
        if (r) exp_ovr++;
    endtask

    task automatic check_zero(input string tag);
        check(tag, {o_a, o_b, o_op, tx_data}, 0);
        check(tag, {tx_start, busy, to_p, ovr_p}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        s_tick  = 1'b0;
        rx_data = '0;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (3) cyc();
        check_zero("reset");
        rst_n = 1'b1;
        cyc();

        issue(8'h05, 8'h03, OP_ADD, 2, 2);
        check("add_res", tx_data, 8'h08);
        release_tx(3, 1'b0);

        send(8'h11, 1'b0);
        s_tick = 1'b1;
        repeat (TT - 1) cyc();
        check("to_early", to_p, 0);
        cyc();
        s_tick = 1'b0;
        check("to_pulse", to_p, 1);
        exp_to++;
        check("to_A_kept", {o_a, o_b, o_op}, {8'h05, 8'h03, 8'h20});
        check("to_idle", busy, 0);
        cyc();
        check("to_single", to_p, 0);
        issue(8'h07, 8'h02, OP_SUB, 1, 1);
        check("sub_res", tx_data, 8'h05);
        release_tx(2, 1'b0);

        send(8'h30, 1'b0);
        send(8'h12, 1'b0);
        s_tick = 1'b1;
        repeat (TT - 1) cyc();
        send(OP_ADD, 1'b1);
        check_commit(8'h30, 8'h12, OP_ADD);
        release_tx(1, 1'b0);

        issue(8'h40, 8'h01, OP_SRL, 0, 0);
        rx_data = 8'hAA;
        rx_done = 1'b1;
        cyc();
        rx_done = 1'b0;
        check("ovr1", ovr_p, 1);
        cyc();
        check("ovr_clr", ovr_p, 0);
        rx_done = 1'b1;
        tx_done = 1'b1;
        cyc();
        rx_done = 1'b0;
        tx_done = 1'b0;
        check("ovr2", ovr_p, 1);
        check("ovr_idle", busy, 0);
        exp_ovr += 2;
        issue(8'h09, 8'h04, OP_OR, 0, 0);
        check("or_res", tx_data, 8'h0D);
        release_tx(2, 1'b0);

        issue(8'h0F, 8'h3C, OP_AND, 0, 0);
        check("and_res", tx_data, 8'h0C);
        release_tx(0, 1'b0);
        issue(8'h81, 8'h01, OP_SRA, 0, 0);
        check("sra_res", tx_data, 8'hC0);
        release_tx(0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 7));
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 1) b = 8'($urandom_range(0, 255));
            issue(a, b, op, $urandom_range(0, 10), $urandom_range(0, 10));
            release_tx($urandom_range(0, 5), 1'b1);
            idle($urandom_range(0, 4));
        end

        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        rst_n = 1'b0;
        #1;
        check_zero("rst_wait_op");
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("rst1_nostart", tx_start, 0);
        end
        issue(8'h01, 8'h02, OP_XOR, 0, 0);
        release_tx(1, 1'b0);

        send(8'h21, 1'b0);
        send(8'h22, 1'b0);
        send(OP_NOR, 1'b0);
        cyc();
        check("send_state", tx_start, 1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_send");
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("rst2_nostart", {tx_start, busy}, 0);
        end
        issue(8'hF0, 8'h0F, OP_NOR, 1, 1);
        release_tx(1, 1'b0);

        cyc();
        check("n_starts", mon_start, exp_start);
        check("n_timeouts", mon_to, exp_to);
        check("n_overruns", mon_ovr, exp_ovr);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
